dmem_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port 32×8 `DataMemory`. It sits between the instruction-fetch unit (port 0) and the load/store unit (port 1) and the memory's `address`/`write_data`/`mem_write_sig`/`read_data` pins. It serialises accesses, generates the one-cycle write strobe and returns registered read data with a one-cycle acknowledge per transaction.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/rr_pick2.sv | 20 ++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding and default widths for dmem_arbiter
// Purpose: FSM state codes and default address/data widths for the arbiter.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 5;
  localparam int DMEM_DATA_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT,
    S_ACK   = ST_ACK
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
// Purpose: choose one of two requesters, favouring the one not granted last.
// Ports:
//   req[1:0]    in   request per port
//   last_grant  in   port that won the previous arbitration
//   valid       out  at least one request present
//   winner      out  selected port index
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  // On a tie the port that did not win last time goes next; otherwise the
  // lone requester wins (req[1] alone -> 1, req[0] alone -> 0).
  assign winner = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter and sequencer for the single-port data memory
// Purpose: serialise port 0 (fetch) and port 1 (load/store) accesses to the
// memory, drive a one-cycle write strobe and return registered read data with
// a one-cycle acknowledge.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   r0_*/r1_* req/we/addr/wdata      requester command inputs
//   r0_*/r1_* ack/rdata              completion pulse and held read result
//   mem_address/mem_write_data       memory address and write data
//   mem_write_sig                    one-cycle write strobe
//   mem_read_data                    combinational memory read data
//   busy                             transaction in progress
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_sig,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              cur_id_q, cur_id_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
  logic              mem_write_sig_q, mem_write_sig_d;
  logic              r0_ack_q, r0_ack_d;
  logic              r1_ack_q, r1_ack_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

  logic pick_valid;
  logic pick_winner;

  rr_pick2 u_pick (
    .req        ({r1_req, r0_req}),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    cur_id_d         = cur_id_q;
    cmd_we_d         = cmd_we_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_write_sig_d  = 1'b0;
    r0_ack_d         = 1'b0;
    r1_ack_d         = 1'b0;
    r0_rdata_d       = r0_rdata_q;
    r1_rdata_d       = r1_rdata_q;

    case (state_q)
      S_IDLE: begin
        // Command is captured here only; later input changes are ignored.
        if (pick_valid) begin
          state_d          = S_GRANT;
          last_grant_d     = pick_winner;
          cur_id_d         = pick_winner;
          cmd_we_d         = pick_winner ? r1_we    : r0_we;
          mem_address_d    = pick_winner ? r1_addr  : r0_addr;
          mem_write_data_d = pick_winner ? r1_wdata : r0_wdata;
          // Registered so the strobe is high for exactly the GRANT cycle.
          mem_write_sig_d  = pick_winner ? r1_we    : r0_we;
        end
      end
      S_GRANT: begin
        state_d = S_ACK;
        if (cur_id_q) r1_ack_d = 1'b1;
        else          r0_ack_d = 1'b1;
        if (!cmd_we_q) begin
          if (cur_id_q) r1_rdata_d = mem_read_data;
          else          r0_rdata_d = mem_read_data;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      last_grant_q     <= 1'b1;
      cur_id_q         <= 1'b0;
      cmd_we_q         <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_write_sig_q  <= 1'b0;
      r0_ack_q         <= 1'b0;
      r1_ack_q         <= 1'b0;
      r0_rdata_q       <= '0;
      r1_rdata_q       <= '0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      cur_id_q         <= cur_id_d;
      cmd_we_q         <= cmd_we_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_sig_q  <= mem_write_sig_d;
      r0_ack_q         <= r0_ack_d;
      r1_ack_q         <= r1_ack_d;
      r0_rdata_q       <= r0_rdata_d;
      r1_rdata_q       <= r1_rdata_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write_sig  = mem_write_sig_q;
  assign r0_ack         = r0_ack_q;
  assign r1_ack         = r1_ack_q;
  assign r0_rdata       = r0_rdata_q;
  assign r1_rdata       = r1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0_req, r0_we, r1_req, r1_we;
  logic [4:0] r0_addr, r1_addr;
  logic [7:0] r0_wdata, r1_wdata;
  logic       r0_ack, r1_ack;
  logic [7:0] r0_rdata, r1_rdata;
  logic [4:0] mem_address;
  logic [7:0] mem_write_data;
  logic       mem_write_sig;
  logic [7:0] mem_read_data;
  logic       busy;

  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .r0_req         (r0_req),
    .r0_we          (r0_we),
    .r0_addr        (r0_addr),
    .r0_wdata       (r0_wdata),
    .r1_req         (r1_req),
    .r1_we          (r1_we),
    .r1_addr        (r1_addr),
    .r1_wdata       (r1_wdata),
    .r0_ack         (r0_ack),
    .r0_rdata       (r0_rdata),
    .r1_ack         (r1_ack),
    .r1_rdata       (r1_rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write_sig  (mem_write_sig),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  // DataMemory model: combinational read, write on rising edge with strobe.
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) if (mem_write_sig) mem[mem_address] <= mem_write_data;

  typedef struct {
    bit         port;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_r0;
    logic [7:0] exp_r1;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [4:0] a, input logic [7:0] d);
    if (!port) begin
      r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wsig"},  mem_write_sig, 0);
    chk({tag, "_addr"},  mem_address, 0);
    chk({tag, "_wdata"}, mem_write_data, 0);
    chk({tag, "_ack0"},  r0_ack, 0);
    chk({tag, "_ack1"},  r1_ack, 0);
    chk({tag, "_rd0"},   r0_rdata, 0);
    chk({tag, "_rd1"},   r1_rdata, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, wp, other, bcnt, acks, c0, c1;
    bit got;
    int ack_id[$];
    int ack_cyc[$];

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h40; mem[2] = 8'h12; mem[5] = 8'hAA; mem[9] = 8'h99;

    r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_we = 0; r1_addr = 0; r1_wdata = 0;

    //            port we addr   wdata  exp_r0 exp_r1
    tbl[0] = '{1'b0, 1'b0, 5'd5,  8'h00, 8'hAA, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 5'd17, 8'h3C, 8'hAA, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 5'd17, 8'h00, 8'h3C, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h3C, 8'h40};
    tbl[4] = '{1'b0, 1'b1, 5'd31, 8'h55, 8'h3C, 8'h40};
    tbl[5] = '{1'b1, 1'b0, 5'd31, 8'h00, 8'h3C, 8'h55};
    tbl[6] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'h55, 8'h55};
    tbl[7] = '{1'b1, 1'b1, 5'd0,  8'hFF, 8'h55, 8'h55};
    tbl[8] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h55, 8'hFF};

    do_reset();

    // Single-port transactions from the table.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].port, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      lat = 0; wp = 0; other = 0; bcnt = 0; got = 0;
      while (!got && lat < 8) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (busy) bcnt++;
        if (mem_write_sig) begin
          wp++;
          chk($sformatf("v%0d_waddr", i), mem_address, tbl[i].addr);
          chk($sformatf("v%0d_wdata", i), mem_write_data, tbl[i].wdata);
        end
        if (tbl[i].port ? r0_ack : r1_ack) other++;
        if (tbl[i].port ? r1_ack : r0_ack) got = 1;
      end
      drive(tbl[i].port, 1'b0, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_wpulses", i), wp, {31'd0, tbl[i].we});
      chk($sformatf("v%0d_other_ack", i), other, 0);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, 2);
      chk($sformatf("v%0d_r0_rdata", i), r0_rdata, tbl[i].exp_r0);
      chk($sformatf("v%0d_r1_rdata", i), r1_rdata, tbl[i].exp_r1);
      @(posedge clk);
      #1;
    end

    // Both ports request from reset and keep requesting: 0,1,0,1 every 3 cycles.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 5'd9, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 5'd2, 8'h00);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (r0_ack) begin ack_id.push_back(0); ack_cyc.push_back(c); end
      if (r1_ack) begin ack_id.push_back(1); ack_cyc.push_back(c); end
      if (ack_id.size() >= 4) begin r0_req = 1'b0; r1_req = 1'b0; end
    end
    chk("tie_ack_count", ack_id.size(), 4);
    if (ack_id.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("tie_id%0d", j), ack_id[j], j % 2);
        chk($sformatf("tie_cyc%0d", j), ack_cyc[j], 2 + 3 * j);
      end
    end
    chk("tie_r0_rdata", r0_rdata, 8'h99);
    chk("tie_r1_rdata", r1_rdata, 8'h12);

    // Address changes during GRANT must not affect the in-flight read.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 5'd5, 8'h00);
    @(posedge clk);
    @(negedge clk);
    r0_addr = 5'd9;
    chk("chg_grant_addr", mem_address, 5);
    acks = 0;
    for (int c = 2; c <= 7; c++) begin
      if (c > 2) @(negedge clk);
      if (c > 2 || 1) begin
        @(posedge clk);
        @(negedge clk);
        if (r0_ack) begin acks++; r0_req = 1'b0; end
      end
    end
    chk("chg_acks", acks, 1);
    chk("chg_r0_rdata", r0_rdata, 8'hAA);

    // Reset asserted during a GRANT write: no commit, no ack, reset values.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 5'd2, 8'hFF);
    @(posedge clk);
    #2;
    chk("rst_mid_wsig_before", mem_write_sig, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    r1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (r0_ack || r1_ack) acks++;
    end
    chk("rst_mid_acks", acks, 0);
    chk("rst_mid_mem2", mem[2], 8'h12);
    chk("rst_mid_busy", busy, 0);

    // r0 holds req through its ack: a second transaction follows.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 5'd5, 8'h00);
    acks = 0; c0 = 0; c1 = 0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (r0_ack) begin
        acks++;
        if (acks == 1) c0 = c;
        if (acks == 2) begin c1 = c; r0_req = 1'b0; end
      end
    end
    chk("hold_acks", acks, 2);
    chk("hold_first_cyc", c0, 2);
    chk("hold_second_cyc", c1, 5);

    // r0 drops req correctly: exactly one ack.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 5'd9, 8'h00);
    acks = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (r0_ack) begin acks++; r0_req = 1'b0; end
    end
    chk("drop_acks", acks, 1);
    chk("drop_r0_rdata", r0_rdata, 8'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
